// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first two's-complement subtractor: diff = a - b - bin over WIDTH cycles.
// One full-subtractor cell, a borrow flop and a start/done handshake with held results.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nstate;
    logic [WIDTH-1:0] areg, breg, rreg, rnext;
    logic [CW-1:0]    cnt;
    logic             borrow, amsb, bmsb;
    logic             x, y, d, nb, last;

    // Full-subtractor cell working on the current LSBs and the stored borrow.
    always_comb begin
        x     = areg[0];
        y     = breg[0];
        d     = x ^ y ^ borrow;
        nb    = (~x & y) | (~(x ^ y) & borrow);
        last  = (cnt == CW'(WIDTH - 1));
        rnext = WIDTH'({d, rreg} >> 1);
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start) nstate = RUN;
            RUN:     if (last)  nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            areg   <= '0;
            breg   <= '0;
            rreg   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            amsb   <= 1'b0;
            bmsb   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        areg   <= a;
                        breg   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        rreg   <= '0;
                        amsb   <= a[WIDTH-1];
                        bmsb   <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    areg   <= areg >> 1;
                    breg   <= breg >> 1;
                    rreg   <= rnext;
                    borrow <= nb;
                    cnt    <= cnt + CW'(1);
                    // The final bit is folded straight into the published result.
                    if (last) begin
                        diff <= rnext;
                        bout <= nb;
                        ovf  <= (amsb != bmsb) & (d != amsb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, corner-case
// sequences and randomized operations checked against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk, rst, start, bin;
    logic [W-1:0] a, b;
    logic         busy, done, bout, ovf;
    logic [W-1:0] diff;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vbin;
        logic [7:0] eDiff;
        logic       eBout;
        logic       eOvf;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                         output logic [7:0] eDiff, output logic eBout, output logic eOvf);
        int r, sa, sb, sr;
        r     = int'(ia) - int'(ib) - int'(ibin);
        eDiff = r[7:0];
        eBout = (r < 0);
        sa    = ia[7] ? int'(ia) - 256 : int'(ia);
        sb    = ib[7] ? int'(ib) - 256 : int'(ib);
        sr    = sa - sb - int'(ibin);
        eOvf  = (sr > 127) || (sr < -128);
    endtask

    // Issue one start pulse, scramble the inputs, then wait (bounded) for done.
    task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                                 output int lat, output int busyCnt);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; bin = ibin;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        lat = 0; busyCnt = 0;
        while (!done && lat < 40) begin
            if (busy) busyCnt++;
            @(negedge clk);
            lat++;
        end
        if (busy) busyCnt++;
    endtask

    initial begin
        int lat, busyCnt, dones, gap;
        logic [7:0] eDiff;
        logic eBout, eOvf;

        vecs[0] = '{8'd10,  8'd3,   1'b0, 8'h07, 1'b0, 1'b0};
        vecs[1] = '{8'd3,   8'd10,  1'b0, 8'hF9, 1'b1, 1'b0};
        vecs[2] = '{8'h80,  8'h01,  1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F,  8'hFF,  1'b0, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h00,  8'h00,  1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h55,  8'h55,  1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h80,  8'h00,  1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[7] = '{8'hFF,  8'hFF,  1'b1, 8'hFF, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset diff", 32'(diff), 32'd0);
        checkOutput("reset bout", 32'(bout), 32'd0);
        checkOutput("reset ovf",  32'(ovf),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vbin, lat, busyCnt);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd8);
            checkOutput($sformatf("vec%0d busy cycles", i), 32'(busyCnt), 32'd9);
            checkOutput($sformatf("vec%0d diff", i), 32'(diff), 32'(vecs[i].eDiff));
            checkOutput($sformatf("vec%0d bout", i), 32'(bout), 32'(vecs[i].eBout));
            checkOutput($sformatf("vec%0d ovf", i),  32'(ovf),  32'(vecs[i].eOvf));
            @(negedge clk);
            checkOutput($sformatf("vec%0d done pulse", i), 32'(done), 32'd0);
            checkOutput($sformatf("vec%0d idle", i), 32'(busy), 32'd0);
        end

        // Results hold in IDLE while inputs wander.
        repeat (3) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom);
        end
        checkOutput("hold diff", 32'(diff), 32'h0FF);
        checkOutput("hold bout", 32'(bout), 32'd1);

        // A start while busy is ignored, not queued.
        @(negedge clk);
        start = 1'b1; a = 8'd9; b = 8'd4; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'd1; b = 8'd2;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        checkOutput("ignored start dones", 32'(dones), 32'd1);
        checkOutput("ignored start diff", 32'(diff), 32'h05);

        // Start held high: accepted on the first IDLE cycle, WIDTH+2 throughput.
        start = 1'b1; a = 8'd20; b = 8'd5; bin = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("held start diff", 32'(diff), 32'd15);
        gap = 0;
        @(negedge clk);
        gap++;
        checkOutput("held start idle gap", 32'(busy), 32'd0);
        while (!done && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        checkOutput("held start throughput", 32'(gap), 32'd10);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of RUN aborts with no done pulse.
        start = 1'b1; a = 8'd200; b = 8'd100; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort diff", 32'(diff), 32'd0);
        checkOutput("abort bout", 32'(bout), 32'd0);
        checkOutput("abort ovf",  32'(ovf),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checkOutput("abort no activity", 32'(dones), 32'd0);
        applyStimulus(8'd200, 8'd100, 1'b0, lat, busyCnt);
        model(8'd200, 8'd100, 1'b0, eDiff, eBout, eOvf);
        checkOutput("post-reset latency", 32'(lat), 32'd8);
        checkOutput("post-reset diff", 32'(diff), 32'h64);
        checkOutput("post-reset bout", 32'(bout), 32'd0);
        checkOutput("post-reset ovf",  32'(ovf),  32'(eOvf));

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic rbin;
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            if (i == 0) begin ra = 8'h80; rb = 8'h7F; end
            model(ra, rb, rbin, eDiff, eBout, eOvf);
            applyStimulus(ra, rb, rbin, lat, busyCnt);
            checkOutput($sformatf("rand%0d latency", i), 32'(lat), 32'd8);
            checkOutput($sformatf("rand%0d diff a=%0h b=%0h bin=%0d", i, ra, rb, rbin), 32'(diff), 32'(eDiff));
            checkOutput($sformatf("rand%0d bout", i), 32'(bout), 32'(eBout));
            checkOutput($sformatf("rand%0d ovf", i),  32'(ovf),  32'(eOvf));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
